// File: rtl/snn_pkg.sv
// Shared constants, payload types and arithmetic helpers for the SNN learning datapath.
package snn_pkg;

  localparam int unsigned M       = 784;
  localparam int unsigned N       = 16;
  localparam int unsigned W       = 24;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DEL_LAT = 2;
  localparam int unsigned IDX_W   = 10;
  localparam int unsigned NID_W   = 4;

  typedef struct packed {
    logic [NID_W-1:0] neuron;
    logic [IDX_W-1:0] idx;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  typedef struct packed {
    logic         valid;
    tag_t         tag;
    logic [W-1:0] plus;
    logic [W-1:0] minus;
  } upd_t;

  // Unsigned w + plus - minus, clamped to [0, 2^W-1].
  function automatic logic [W-1:0] sat_update(input logic [W-1:0] w,
                                              input logic [W-1:0] plus,
                                              input logic [W-1:0] minus);
    logic signed [W+1:0] s;
    s = signed'({2'b00, w}) + signed'({2'b00, plus}) - signed'({2'b00, minus});
    if (s < 0) begin
      return '0;
    end else if (s > signed'({2'b00, {W{1'b1}}})) begin
      return '1;
    end else begin
      return s[W-1:0];
    end
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [NID_W-1:0] lowest_one(input logic [N-1:0] v);
    logic [NID_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = NID_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_updater_tag_delay_line.sv
// Fixed-depth shift register carrying a valid bit and a payload word.
module tag_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/weight_updater.sv
// STDP weight updater: tags swept indices with the winner, then does a saturating RMW on the weight RAM.
module weight_updater
  import snn_pkg::*;
#(
  parameter int unsigned M       = snn_pkg::M,
  parameter int unsigned DEL_LAT = snn_pkg::DEL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      start_wch,
  input  logic              learn_en,
  input  logic [IDX_W-1:0]  ip_select,
  input  logic [W-1:0]      del_w_plus,
  input  logic [W-1:0]      del_w_minus,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_rd_addr,
  input  logic [W-1:0]      wt_rd_data,
  output logic              wt_wr_en,
  output logic [ADDR_W-1:0] wt_wr_addr,
  output logic [W-1:0]      wt_wr_data,
  output logic              busy,
  output logic              done
);

  function automatic logic [ADDR_W-1:0] tag_addr(input tag_t t);
    return ADDR_W'(32'(t.neuron) * M + 32'(t.idx));
  endfunction

  logic [NID_W-1:0] winner_q;
  tag_t             s0_tag;
  logic             dl_valid;
  logic             dl_any;
  logic [TAG_W-1:0] dl_data;
  tag_t             dl_tag;
  upd_t             rd_q;
  upd_t             cmp_q;

  // The entry sampled with a start strobe still belongs to the previous winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q <= '0;
    end else if (|start_wch) begin
      winner_q <= lowest_one(start_wch);
    end
  end

  assign s0_tag = '{neuron: winner_q, idx: ip_select};

  tag_delay_line #(
    .DEPTH (DEL_LAT),
    .WIDTH (TAG_W)
  ) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ip_select != '0),
    .in_data   (s0_tag),
    .out_valid (dl_valid),
    .out_data  (dl_data),
    .any_valid (dl_any)
  );

  assign dl_tag = tag_t'(dl_data);

  // Read stage: deltas line up with the delayed tag here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      wt_rd_en   <= 1'b0;
      wt_rd_addr <= '0;
    end else begin
      rd_q       <= '{valid: dl_valid, tag: dl_tag, plus: del_w_plus, minus: del_w_minus};
      wt_rd_en   <= dl_valid;
      wt_rd_addr <= tag_addr(dl_tag);
    end
  end

  // Compute stage: RAM data arrives one cycle after the read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q      <= '0;
      wt_wr_en   <= 1'b0;
      wt_wr_addr <= '0;
      wt_wr_data <= '0;
      done       <= 1'b0;
    end else begin
      cmp_q      <= rd_q;
      wt_wr_en   <= cmp_q.valid & learn_en;
      wt_wr_addr <= tag_addr(cmp_q.tag);
      wt_wr_data <= sat_update(wt_rd_data, cmp_q.plus, cmp_q.minus);
      done       <= cmp_q.valid && (cmp_q.tag.idx == IDX_W'(M - 1));
    end
  end

  assign busy = !rst && (dl_any || rd_q.valid || cmp_q.valid || (ip_select != '0));

endmodule
